// File: rtl/fir_tap_accumulator.sv
// ============================================================================
// Module   : fir_tap_accumulator
// Function : Sums TAP_COUNT signed products into one registered output sample
//            with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_tap_accumulator #(
    parameter int DATA_WIDTH = 38,
    parameter int TAP_COUNT  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          prod_valid,
    input  logic [DATA_WIDTH-1:0]         prod_in,
    output logic                          prod_ready,
    output logic [$clog2(TAP_COUNT)-1:0]  tap_idx,
    output logic [DATA_WIDTH-1:0]         acc_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int IDX_WIDTH = $clog2(TAP_COUNT);
    localparam logic [IDX_WIDTH-1:0] c_LAST_IDX = IDX_WIDTH'(TAP_COUNT - 1);
    localparam logic [IDX_WIDTH-1:0] c_IDX_ONE  = IDX_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_acc_out;
    logic [IDX_WIDTH-1:0]  r_tap_idx;
    logic                  r_out_valid;
    logic                  w_accept;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_sum;

    // Modulo-2^DATA_WIDTH add: two's complement wrap falls out of truncation.
    assign w_sum = r_acc + prod_in;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_accept = prod_valid;
                w_last   = prod_valid && (r_tap_idx == c_LAST_IDX);
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_acc_out   <= '0;
            r_tap_idx   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_acc     <= '0;
                r_tap_idx <= '0;
            end
            if (w_accept) begin
                r_acc <= w_sum;
                if (w_last) begin
                    r_acc_out   <= w_sum;
                    r_out_valid <= 1'b1;
                    r_tap_idx   <= '0;
                end else begin
                    r_tap_idx <= r_tap_idx + c_IDX_ONE;
                end
            end
            if ((r_state == S_HOLD) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign prod_ready = (r_state == S_ACCUM);
    assign busy       = (r_state != S_IDLE);
    assign tap_idx    = r_tap_idx;
    assign acc_out    = r_acc_out;
    assign out_valid  = r_out_valid;

endmodule

`default_nettype wire
